// File: rtl/pixel_cmd_pkg.sv
// Shared types, opcodes and argument counts for the pixel command parser.
// Optional feature macro: RECT_FILL_EN (enables the RECT opcode).
package pixel_cmd_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned COORD_W    = 6;
    localparam int unsigned COLOR_W    = 12;
    localparam int unsigned ARG_CNT_W  = 3;
    // Largest packet (RECT) keeps 5 argument bytes; its 6th (c_lo) is used straight off the bus.
    localparam int unsigned MAX_STORED = 5;

    localparam logic [BYTE_W-1:0] OP_PIXEL = 8'h01;
    localparam logic [BYTE_W-1:0] OP_CLEAR = 8'h02;
    localparam logic [BYTE_W-1:0] OP_RECT  = 8'h03;

    localparam int unsigned PIXEL_ARGS = 4;
    localparam int unsigned CLEAR_ARGS = 2;
    localparam int unsigned RECT_ARGS  = 6;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARGS = 2'd1,
        FILL = 2'd2
    } state_t;

    // Index of the final argument byte for a given opcode.
    function automatic logic [ARG_CNT_W-1:0] last_arg_idx(input logic [BYTE_W-1:0] op);
        case (op)
            OP_PIXEL: return ARG_CNT_W'(PIXEL_ARGS - 1);
            OP_CLEAR: return ARG_CNT_W'(CLEAR_ARGS - 1);
            default:  return ARG_CNT_W'(RECT_ARGS - 1);
        endcase
    endfunction

endpackage

// File: rtl/fill_scanner.sv
// Row-major rectangle scanner: emits one coordinate per WRITE_GAP+1 cycles.
// The start cycle itself emits (x0,y0) so the first write lands one cycle later.
module fill_scanner
    import pixel_cmd_pkg::*;
#(
    parameter int unsigned WRITE_GAP = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   abort,
    input  logic   advance,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output logic   emit_c,
    output coord_t cur_x_c,
    output coord_t cur_y_c,
    output logic   last_c
);

    localparam int unsigned GAP_W = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP);

    logic             active_q;
    coord_t           cx_q, cy_q;
    coord_t           row_x0_q, end_x_q, end_y_q;
    logic [GAP_W-1:0] gap_q;

    coord_t end_x_c, end_y_c, row_x0_c;
    coord_t next_x_c, next_y_c;

    // Current point, bounds (bypassed from inputs on start) and next row-major point.
    always_comb begin
        cur_x_c  = start ? x0 : cx_q;
        cur_y_c  = start ? y0 : cy_q;
        end_x_c  = start ? x1 : end_x_q;
        end_y_c  = start ? y1 : end_y_q;
        row_x0_c = start ? x0 : row_x0_q;
        emit_c   = start | (active_q & advance & (gap_q == '0));
        last_c   = (cur_x_c == end_x_c) && (cur_y_c == end_y_c);
        next_x_c = cur_x_c + 6'd1;
        next_y_c = cur_y_c;
        if (cur_x_c == end_x_c) begin
            next_x_c = row_x0_c;
            next_y_c = cur_y_c + 6'd1;
        end
    end

    // Scan position, bounds and pacing counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            row_x0_q <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            gap_q    <= '0;
        end else if (abort) begin
            active_q <= 1'b0;
            gap_q    <= '0;
        end else begin
            if (start) begin
                row_x0_q <= x0;
                end_x_q  <= x1;
                end_y_q  <= y1;
            end
            if (emit_c) begin
                active_q <= ~last_c;
                cx_q     <= next_x_c;
                cy_q     <= next_y_c;
                gap_q    <= GAP_LOAD;
            end else if (active_q && (gap_q != '0)) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_cmd_parser.sv
// Decodes SPI command bytes into a pixel-write stream for the LED matrix.
// Optional feature macro: RECT_FILL_EN (decodes opcode 0x03 as a rectangle fill).
module pixel_cmd_parser
    import pixel_cmd_pkg::*;
#(
    parameter int unsigned DIM       = 64,
    parameter int unsigned WRITE_GAP = 0
) (
    input  logic        clk_in,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        pkt_abort,
    output logic        write_en,
    output logic [5:0]  write_x,
    output logic [5:0]  write_y,
    output logic [11:0] write_color,
    output logic        busy,
    output logic        err,
    output logic [7:0]  drop_cnt
);

    state_t                               state_q, state_d;
    logic [ARG_CNT_W-1:0]                 arg_cnt_q, arg_cnt_d;
    logic [MAX_STORED-1:0][COORD_W-1:0]   args_q, args_d;
    logic [BYTE_W-1:0]                    op_q, op_d;
    color_t                               fill_color_q, fill_color_d;

    logic        write_en_d;
    coord_t      write_x_d, write_y_d;
    color_t      write_color_d;
    logic        busy_d, err_d;
    logic [7:0]  drop_cnt_d;

    logic        opcode_known_c;
    logic        final_arg_c;
    logic        rect_bad_c;
    logic        start_c;
    coord_t      sx0_c, sy0_c, sx1_c, sy1_c;
    color_t      start_color_c;

    logic        scan_emit_c;
    coord_t      scan_x_c, scan_y_c;
    logic        scan_last_c;

    // Upper argument bits only matter for some opcodes/builds.
    logic        unused_args_c;
    assign unused_args_c = ^args_q;

    // Opcode recognition for the byte arriving in IDLE.
    always_comb begin
`ifdef RECT_FILL_EN
        opcode_known_c = (rx_byte == OP_PIXEL) || (rx_byte == OP_CLEAR) || (rx_byte == OP_RECT);
`else
        opcode_known_c = (rx_byte == OP_PIXEL) || (rx_byte == OP_CLEAR);
`endif
    end

    // Final-argument detection and fill launch parameters.
    always_comb begin
        final_arg_c   = (state_q == ARGS) && rx_valid && !pkt_abort &&
                        (arg_cnt_q == last_arg_idx(op_q));
        rect_bad_c    = 1'b0;
        start_c       = 1'b0;
        sx0_c         = '0;
        sy0_c         = '0;
        sx1_c         = coord_t'(DIM - 1);
        sy1_c         = coord_t'(DIM - 1);
        start_color_c = {args_q[0][3:0], rx_byte};
        if (final_arg_c && (op_q == OP_CLEAR)) begin
            start_c = 1'b1;
        end
`ifdef RECT_FILL_EN
        if (op_q == OP_RECT) begin
            sx0_c         = args_q[0];
            sy0_c         = args_q[1];
            sx1_c         = args_q[2];
            sy1_c         = args_q[3];
            start_color_c = {args_q[4][3:0], rx_byte};
            rect_bad_c    = final_arg_c && ((args_q[0] > args_q[2]) || (args_q[1] > args_q[3]));
            start_c       = final_arg_c && !rect_bad_c;
        end
`endif
    end

    fill_scanner #(
        .WRITE_GAP (WRITE_GAP)
    ) u_scanner (
        .clk     (clk_in),
        .rst_n   (resetn),
        .start   (start_c),
        .abort   (pkt_abort),
        .advance ((state_q == FILL) && !pkt_abort),
        .x0      (sx0_c),
        .y0      (sy0_c),
        .x1      (sx1_c),
        .y1      (sy1_c),
        .emit_c  (scan_emit_c),
        .cur_x_c (scan_x_c),
        .cur_y_c (scan_y_c),
        .last_c  (scan_last_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        arg_cnt_d     = arg_cnt_q;
        args_d        = args_q;
        op_d          = op_q;
        fill_color_d  = fill_color_q;
        write_en_d    = 1'b0;
        write_x_d     = write_x;
        write_y_d     = write_y;
        write_color_d = write_color;
        err_d         = err;
        drop_cnt_d    = drop_cnt;

        if (pkt_abort) begin
            state_d   = IDLE;
            arg_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (opcode_known_c) begin
                            op_d      = rx_byte;
                            arg_cnt_d = '0;
                            state_d   = ARGS;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ARGS: begin
                    if (final_arg_c) begin
                        arg_cnt_d = '0;
                        state_d   = IDLE;
                        if (op_q == OP_PIXEL) begin
                            write_en_d    = 1'b1;
                            write_x_d     = args_q[0];
                            write_y_d     = args_q[1];
                            write_color_d = {args_q[2][3:0], rx_byte};
                        end
                        if (rect_bad_c) begin
                            err_d = 1'b1;
                        end
                        if (start_c) begin
                            fill_color_d = start_color_c;
                            state_d      = scan_last_c ? IDLE : FILL;
                        end
                    end else if (rx_valid) begin
                        args_d[arg_cnt_q] = rx_byte[COORD_W-1:0];
                        arg_cnt_d         = arg_cnt_q + 3'd1;
                    end
                end
                FILL: begin
                    if (rx_valid) begin
                        err_d = 1'b1;
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt_d = drop_cnt + 8'd1;
                        end
                    end
                    if (scan_emit_c && scan_last_c) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (scan_emit_c) begin
            write_en_d    = 1'b1;
            write_x_d     = scan_x_c;
            write_y_d     = scan_y_c;
            write_color_d = start_c ? start_color_c : fill_color_q;
        end

        busy_d = (state_d == FILL);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            arg_cnt_q    <= '0;
            args_q       <= '0;
            op_q         <= '0;
            fill_color_q <= '0;
            write_en     <= 1'b0;
            write_x      <= '0;
            write_y      <= '0;
            write_color  <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            arg_cnt_q    <= arg_cnt_d;
            args_q       <= args_d;
            op_q         <= op_d;
            fill_color_q <= fill_color_d;
            write_en     <= write_en_d;
            write_x      <= write_x_d;
            write_y      <= write_y_d;
            write_color  <= write_color_d;
            busy         <= busy_d;
            err          <= err_d;
            drop_cnt     <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pixel_cmd_parser.sv
// Directed bench for pixel_cmd_parser with a write scoreboard.
module tb_pixel_cmd_parser;

    logic        clk_in = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        pkt_abort;
    logic        write_en;
    logic [5:0]  write_x;
    logic [5:0]  write_y;
    logic [11:0] write_color;
    logic        busy;
    logic        err;
    logic [7:0]  drop_cnt;

    pixel_cmd_parser #(
        .DIM       (64),
        .WRITE_GAP (0)
    ) dut (
        .clk_in      (clk_in),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .pkt_abort   (pkt_abort),
        .write_en    (write_en),
        .write_x     (write_x),
        .write_y     (write_y),
        .write_color (write_color),
        .busy        (busy),
        .err         (err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [11:0] c;
        logic        b;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  passed = 0;
    int  writes = 0;
    int  cyc = 0;
    int  last_wr_cyc = 0;
    int  w0, t0;
    logic e0;
    logic [7:0] d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    task automatic push_pix(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c);
        exp_q.push_back('{x: x, y: y, c: c, b: 1'b0});
    endtask

    task automatic push_fill(input int x0, input int y0, input int x1, input int y1,
                             input logic [11:0] c);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_q.push_back('{x: 6'(x), y: 6'(y), c: c, b: !((x == x1) && (y == y1))});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk_in);
            #1;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: every write must match the next expected entry.
    always @(negedge clk_in) begin
        if (resetn && write_en) begin
            writes++;
            last_wr_cyc = cyc;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_x", 32'(write_x), 32'(mon_e.x));
                chk("wr_y", 32'(write_y), 32'(mon_e.y));
                chk("wr_color", 32'(write_color), 32'(mon_e.c));
                chk("wr_busy", 32'(busy), 32'(mon_e.b));
            end else begin
                chk("spurious_write", 32'(write_en), 32'd0);
            end
        end
    end

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; pkt_abort = 1'b0;
        idle(3);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_x", 32'(write_x), 32'd0);
        chk("rst_write_y", 32'(write_y), 32'd0);
        chk("rst_write_color", 32'(write_color), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        resetn = 1'b1;
        idle(2);

        // PIXEL 01 05 0A 0F 0F
        w0 = writes;
        push_pix(6'd5, 6'd10, 12'hF0F);
        send(8'h01); send(8'h05); send(8'h0A); send(8'h0F); send(8'h0F);
        chk("pixel_next_cycle", 32'(write_en), 32'd1);
        chk("pixel_busy", 32'(busy), 32'd0);
        drain(20);
        idle(5);
        chk("pixel_count", 32'(writes - w0), 32'd1);

        // CLEAR 02 00 F0
        w0 = writes;
        push_fill(0, 0, 63, 63, 12'h0F0);
        send(8'h02); send(8'h00); send(8'hF0);
        t0 = cyc;
        chk("clear_first_we", 32'(write_en), 32'd1);
        chk("clear_busy_start", 32'(busy), 32'd1);
        drain(5000);
        idle(5);
        chk("clear_count", 32'(writes - w0), 32'd4096);
        chk("clear_span", 32'(last_wr_cyc - t0), 32'd4095);
        chk("clear_busy_end", 32'(busy), 32'd0);
        chk("clear_err", 32'(err), 32'd0);

        // Unknown opcode, then PIXEL with masked coordinate/colour bits
        w0 = writes;
        send(8'h7E);
        idle(3);
        chk("unknown_err", 32'(err), 32'd1);
        chk("unknown_no_write", 32'(writes - w0), 32'd0);
        chk("unknown_no_drop", 32'(drop_cnt), 32'd0);
        push_pix(6'd63, 6'd0, 12'hABC);
        send(8'h01); send(8'hFF); send(8'h40); send(8'hFA); send(8'hBC);
        drain(20);
        idle(5);
        chk("pixel2_count", 32'(writes - w0), 32'd1);

        // CLEAR with bytes dropped during the fill
        w0 = writes;
        push_fill(0, 0, 63, 63, 12'h123);
        send(8'h02); send(8'h01); send(8'h23);
        idle(10);
        send(8'hAA); send(8'hBB); send(8'hCC);
        drain(5000);
        idle(5);
        chk("drop_cnt", 32'(drop_cnt), 32'd3);
        chk("drop_fill_count", 32'(writes - w0), 32'd4096);

        // Abort after 100 fill writes
        w0 = writes;
        push_fill(0, 0, 63, 63, 12'hF00);
        send(8'h02); send(8'h0F); send(8'h00);
        for (int i = 0; i < 500 && (writes - w0) < 100; i++) begin
            @(negedge clk_in);
            #1;
        end
        pkt_abort = 1'b1;
        exp_q.delete();
        @(negedge clk_in);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(write_en), 32'd0);
        pkt_abort = 1'b0;
        idle(10);
        chk("abort_count", 32'(writes - w0), 32'd100);

        // Partial PIXEL then abort (with a byte arriving during abort)
        e0 = err;
        d0 = drop_cnt;
        w0 = writes;
        send(8'h01); send(8'h05); send(8'h0A);
        pkt_abort = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'h01;
        @(negedge clk_in);
        pkt_abort = 1'b0;
        rx_valid  = 1'b0;
        idle(3);
        chk("partial_no_write", 32'(writes - w0), 32'd0);
        chk("partial_err", 32'(err), 32'(e0));
        chk("partial_drop", 32'(drop_cnt), 32'(d0));
        push_pix(6'd7, 6'd9, 12'h102);
        send(8'h01); send(8'h07); send(8'h09); send(8'h01); send(8'h02);
        drain(20);
        idle(5);
        chk("partial_next_count", 32'(writes - w0), 32'd1);

        // Reset in the middle of a fill
        push_fill(0, 0, 63, 63, 12'h555);
        send(8'h02); send(8'h05); send(8'h55);
        repeat (20) @(negedge clk_in);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_write_en", 32'(write_en), 32'd0);
        chk("mid_rst_write_x", 32'(write_x), 32'd0);
        chk("mid_rst_write_y", 32'(write_y), 32'd0);
        chk("mid_rst_color", 32'(write_color), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        @(negedge clk_in);
        resetn = 1'b1;
        w0 = writes;
        idle(5);
        chk("post_rst_no_write", 32'(writes - w0), 32'd0);

`ifdef RECT_FILL_EN
        w0 = writes;
        push_fill(2, 3, 4, 4, 12'hFFF);
        send(8'h03); send(8'h02); send(8'h03); send(8'h04); send(8'h04); send(8'h0F); send(8'hFF);
        drain(50);
        idle(5);
        chk("rect_count", 32'(writes - w0), 32'd6);
        chk("rect_err", 32'(err), 32'd0);
        w0 = writes;
        send(8'h03); send(8'h05); send(8'h00); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        idle(5);
        chk("rect_bad_err", 32'(err), 32'd1);
        chk("rect_bad_no_write", 32'(writes - w0), 32'd0);
`else
        w0 = writes;
        send(8'h03);
        idle(3);
        chk("rect_off_err", 32'(err), 32'd1);
        push_pix(6'd1, 6'd2, 12'h345);
        send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h45);
        drain(20);
        idle(5);
        chk("rect_off_count", 32'(writes - w0), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
